// File: rtl/nmcu_pkg.sv
// nmcu_pkg: definitions shared by the NMCU control and read-back blocks.
// Holds the drain state encoding, the dimension-field width helper and the
// default bus widths used by both nmcu_ctrl and nmcu_out_drain.
package nmcu_pkg;

    localparam int NMCU_ADDR_WIDTH    = 16;
    localparam int NMCU_DATABUS_WIDTH = 32;
    localparam int NMCU_MAX_INPUT_DIM = 16;

    typedef enum logic [2:0] {
        DRN_IDLE,
        DRN_REQ,
        DRN_READ,
        DRN_GAP,
        DRN_FLUSH,
        DRN_DONE
    } drain_state_t;

    // Width of a row/column count field able to hold 0..max_dim inclusive.
    function automatic int nmcu_dim_w(input int max_dim);
        return $clog2(max_dim) + 1;
    endfunction

endpackage

// File: rtl/nmcu_drain_fifo.sv
// nmcu_drain_fifo: small synchronous first-word-fall-through FIFO.
// The head entry is visible on o_data whenever o_valid is high; o_data is
// forced to zero while empty so the stream bus idles at a known value.
// DEPTH must be a power of two so the pointers wrap naturally.
module nmcu_drain_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_occ
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_occ;
    logic                  w_pop;

    // A pop on an empty FIFO is dropped rather than corrupting the pointers.
    assign w_pop   = i_pop && (r_occ != '0);
    assign o_valid = (r_occ != '0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_occ   = r_occ;

    // Pointer and occupancy bookkeeping; push+pop together keeps occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage array; contents need no reset since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/nmcu_out_drain.sv
// nmcu_out_drain: reads the W x H convolution result region back from the
// shared memory after nmcu_ctrl finishes and streams it out row-major with a
// last flag through a small skid FIFO. The memory bus is held only between
// grant and the final read.
// Optional build macro NMCU_DRAIN_RELU_EN: clamp negative words to zero on
// the push path (no extra latency). Undefined: words pass bit-exact.
module nmcu_out_drain
    import nmcu_pkg::*;
#(
    parameter int ADDR_WIDTH    = NMCU_ADDR_WIDTH,
    parameter int DATABUS_WIDTH = NMCU_DATABUS_WIDTH,
    parameter int MAX_INPUT_DIM = NMCU_MAX_INPUT_DIM,
    parameter int FIFO_DEPTH    = 4,
    localparam int DIM_W        = nmcu_dim_w(MAX_INPUT_DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    input  logic [ADDR_WIDTH-1:0]    output_addr,
    input  logic [DIM_W-1:0]         full_output_width,
    input  logic [DIM_W-1:0]         full_output_height,
    output logic                     bus_req,
    input  logic                     bus_gnt,
    output logic                     mem_sel,
    output logic                     mem_w,
    output logic [ADDR_WIDTH-1:0]    address_bus,
    input  logic [DATABUS_WIDTH-1:0] data_bus,
    input  logic                     ready,
    output logic                     m_valid,
    output logic [DATABUS_WIDTH-1:0] m_data,
    output logic                     m_last,
    input  logic                     m_ready
);
    localparam int CW = 2 * DIM_W;
    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OW-1:0] DEPTH_L = OW'(FIFO_DEPTH);

    drain_state_t            r_state;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           r_rd_idx;
    logic                    r_bus_req;
    logic                    r_mem_sel;
    logic                    r_done;

    logic [CW-1:0]           w_count;
    logic [CW-1:0]           w_idx_nxt;
    logic                    w_is_last;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_space;
    logic [DATABUS_WIDTH-1:0] w_push_data;
    logic [DATABUS_WIDTH:0]  w_fifo_q;
    logic                    w_fifo_valid;
    logic [OW-1:0]           w_occ;

    assign w_count   = CW'(full_output_width) * CW'(full_output_height);
    assign w_idx_nxt = r_rd_idx + CW'(1);
    assign w_is_last = (w_idx_nxt == r_count);
    assign w_push    = (r_state == DRN_READ) && r_mem_sel && ready;
    assign w_pop     = w_fifo_valid && m_ready;
    // Room for one more word by the next edge: a pop this cycle frees a slot.
    assign w_space   = (w_occ < DEPTH_L) || w_pop;

`ifdef NMCU_DRAIN_RELU_EN
    assign w_push_data = data_bus[DATABUS_WIDTH-1] ? '0 : data_bus;
`else
    assign w_push_data = data_bus;
`endif

    assign done        = r_done;
    assign busy        = (r_state != DRN_IDLE);
    assign bus_req     = r_bus_req;
    assign mem_sel     = r_mem_sel;
    assign mem_w       = 1'b0;
    assign address_bus = r_mem_sel ? (r_base + ADDR_WIDTH'(r_rd_idx)) : '0;
    assign m_valid     = w_fifo_valid;
    assign m_data      = w_fifo_q[DATABUS_WIDTH-1:0];
    assign m_last      = w_fifo_q[DATABUS_WIDTH];

    // Drain sequencer: bus ownership, one outstanding read, completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DRN_IDLE;
            r_base    <= '0;
            r_count   <= '0;
            r_rd_idx  <= '0;
            r_bus_req <= 1'b0;
            r_mem_sel <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                DRN_IDLE: begin
                    if (start) begin
                        r_base   <= output_addr;
                        r_count  <= w_count;
                        r_rd_idx <= '0;
                        if (w_count == '0) begin
                            r_state <= DRN_DONE;
                        end else begin
                            r_state   <= DRN_REQ;
                            r_bus_req <= 1'b1;
                        end
                    end
                end
                DRN_REQ: begin
                    if (bus_gnt) begin
                        r_state   <= DRN_READ;
                        r_mem_sel <= w_space;
                    end
                end
                DRN_READ: begin
                    if (r_mem_sel) begin
                        if (ready) begin
                            r_mem_sel <= 1'b0;
                            r_rd_idx  <= w_idx_nxt;
                            if (w_is_last) begin
                                r_state   <= DRN_FLUSH;
                                r_bus_req <= 1'b0;
                            end else begin
                                r_state <= DRN_GAP;
                            end
                        end
                    end else if (w_space) begin
                        // FIFO was full; start the read once a slot frees up.
                        r_mem_sel <= 1'b1;
                    end
                end
                DRN_GAP: begin
                    r_state   <= DRN_READ;
                    r_mem_sel <= w_space;
                end
                DRN_FLUSH: begin
                    // Final word is in the FIFO on entry; leave on its handshake.
                    if (w_pop && (w_occ == OW'(1))) begin
                        r_state <= DRN_DONE;
                        r_done  <= 1'b1;
                    end
                end
                DRN_DONE: begin
                    // Arrived from FLUSH with done already raised: finish now.
                    // Arrived from a zero-size start: raise done one cycle later.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= DRN_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= DRN_IDLE;
            endcase
        end
    end

    nmcu_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATABUS_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({w_is_last, w_push_data}),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_q),
        .o_occ   (w_occ)
    );

endmodule

// File: tb/tb_nmcu_out_drain.sv
// Bench for nmcu_out_drain: memory/arbiter/consumer models driven on the
// falling edge, a table of directed drains, hand-written corner sequences,
// and randomized drains checked against a simple index-based reference.
module tb_nmcu_out_drain;
    localparam int AW = 16, DW = 32, FD = 4, DIMW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, done, busy, bus_req, bus_gnt, mem_sel, mem_w, ready;
    logic [AW-1:0] output_addr, address_bus;
    logic [DIMW-1:0] full_output_width, full_output_height;
    logic [DW-1:0] data_bus, m_data;
    logic          m_valid, m_last, m_ready;

    nmcu_out_drain dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .output_addr(output_addr), .full_output_width(full_output_width),
        .full_output_height(full_output_height), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .mem_sel(mem_sel), .mem_w(mem_w),
        .address_bus(address_bus), .data_bus(data_bus), .ready(ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    logic [DW-1:0] mem [0:65535];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model knobs and observations
    int lat, gdly, rmode, stall_left, gcnt, mcnt;
    bit spur, mreal;
    logic [DW-1:0] got_q[$];
    bit            last_q[$];
    logic [AW-1:0] addr_q[$];
    int            hs_q[$];
    int done_cnt, done_cyc, first_gnt, first_sel, viol, pushes, pops, start_cyc;
    bit saw_req, saw_sel, pv, pr, pl;
    logic [DW-1:0] pd;
    int cur_w, cur_h;
    logic [AW-1:0] cur_base;
    int n_pass = 0, n_tot = 0;

    // Falling-edge models: consumer, monitor, arbiter, memory.
    always @(negedge clk) begin
        case (rmode)
            1: m_ready = 1'($urandom_range(0, 1));
            2: begin
                m_ready = !(got_q.size() >= 1 && stall_left > 0);
                if (got_q.size() >= 1 && stall_left > 0) stall_left--;
            end
            default: m_ready = 1'b1;
        endcase
        if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) viol++;
        pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        if (m_valid && m_ready) begin
            got_q.push_back(m_data); last_q.push_back(m_last); hs_q.push_back(cyc); pops++;
        end
        if (done) begin done_cnt++; if (done_cnt == 1) done_cyc = cyc; end
        if (bus_req) saw_req = 1;
        if (mem_sel) begin saw_sel = 1; if (first_sel < 0) first_sel = cyc; end
        if (mem_w !== 1'b0) viol++;
        if (mem_sel && !bus_gnt) viol++;
        gcnt = bus_req ? gcnt + 1 : 0;
        bus_gnt = bus_req && (gcnt > gdly);
        if (bus_gnt && first_gnt < 0) first_gnt = cyc;
        if (mem_sel) begin
            if (!mreal) begin
                mcnt++;
                if (mcnt == lat + 1) begin
                    mreal = 1; ready = 1; data_bus = mem[address_bus];
                    addr_q.push_back(address_bus); pushes++;
                end else begin
                    ready = 0; data_bus = $urandom;
                end
            end
        end else begin
            mreal = 0; mcnt = 0;
            ready = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            data_bus = $urandom;
        end
        if (pushes - pops > FD) viol++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] v);
`ifdef NMCU_DRAIN_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic launch(input int w, input int h, input logic [AW-1:0] base,
                          input int l, input int gd, input int rm, input bit sp);
        lat = l; gdly = gd; rmode = rm; spur = sp; stall_left = 20;
        got_q.delete(); last_q.delete(); addr_q.delete(); hs_q.delete();
        done_cnt = 0; done_cyc = -1; first_gnt = -1; first_sel = -1;
        viol = 0; pushes = 0; pops = 0; saw_req = 0; saw_sel = 0; pv = 0;
        cur_w = w; cur_h = h; cur_base = base;
        full_output_width = DIMW'(w); full_output_height = DIMW'(h); output_addr = base;
        start = 1; start_cyc = cyc;
        step(1);
        start = 0;
        // scramble the inputs: the drain must use only the latched values
        output_addr = AW'($urandom);
        full_output_width = DIMW'($urandom_range(0, 16));
        full_output_height = DIMW'($urandom_range(0, 16));
        chk("busy_rise", busy, 1);
        chk("req_rise", bus_req, (w * h != 0));
    endtask

    task automatic finish_drain();
        int n, bound, errs, lerr, aerr, gerr;
        logic [AW-1:0] a;
        n = cur_w * cur_h;
        bound = 500 + n * (lat + 3) * 6 + gdly;
        for (int i = 0; i < bound && done_cnt == 0; i++) step(1);
        chk("done_seen", done_cnt > 0, 1);
        step(3);
        chk("done_once", done_cnt, 1);
        chk("busy_end", busy, 0);
        chk("nwords", got_q.size(), n);
        errs = 0; lerr = 0; aerr = 0; gerr = 0;
        for (int i = 0; i < n; i++) begin
            a = cur_base + AW'(i);
            if (i < got_q.size()) begin
                if (got_q[i] !== ref_word(mem[a])) begin
                    if (errs == 0) $display("FAIL data[%0d]: got %h expected %h", i, got_q[i], ref_word(mem[a]));
                    errs++;
                end
                if (last_q[i] != (i == n - 1)) lerr++;
            end
            if (i < addr_q.size() && addr_q[i] !== a) aerr++;
        end
        chk("data", errs, 0);
        chk("last", lerr, 0);
        chk("addr_cnt", addr_q.size(), n);
        chk("addr", aerr, 0);
        chk("protocol", viol, 0);
        if (n == 0) begin
            chk("done_time", done_cyc, start_cyc + 2);
            chk("zero_req", saw_req, 0);
            chk("zero_sel", saw_sel, 0);
        end else begin
            if (hs_q.size() > 0) chk("done_time", done_cyc, hs_q[hs_q.size() - 1] + 1);
            chk("first_sel", first_sel, first_gnt + 1);
            if (rmode == 0 && hs_q.size() == n) begin
                chk("first_word", hs_q[0], first_sel + lat + 1);
                for (int i = 0; i + 1 < n; i++) if (hs_q[i + 1] - hs_q[i] != lat + 2) gerr++;
                chk("word_rate", gerr, 0);
            end
        end
    endtask

    typedef struct {
        int w, h; logic [AW-1:0] base; int l, gd, rm;
        int exp_n; logic [DW-1:0] exp_first, exp_last;
    } vec_t;

    initial begin
        vec_t tbl[7];
        logic [DW-1:0] rv [4];
        logic [DW-1:0] rexp [4];
        int k;
        tbl[0] = '{3, 3, 16'h0200, 1, 0, 0,   9, 32'h1000_0200, 32'h1000_0208};
        tbl[1] = '{3, 3, 16'h0200, 1, 7, 0,   9, 32'h1000_0200, 32'h1000_0208};
        tbl[2] = '{3, 3, 16'h0200, 1, 0, 2,   9, 32'h1000_0200, 32'h1000_0208};
        tbl[3] = '{0, 5, 16'h0100, 1, 0, 0,   0, 32'h0,         32'h0};
        tbl[4] = '{2, 2, 16'hFFFE, 2, 0, 0,   4, 32'h1000_FFFE, 32'h1000_0001};
        tbl[5] = '{16, 16, 16'h1234, 0, 3, 1, 256, 32'h1000_1234, 32'h1000_1333};
        tbl[6] = '{1, 1, 16'h0000, 3, 0, 1,   1, 32'h1000_0000, 32'h1000_0000};

        rst = 1; start = 0; output_addr = 0; full_output_width = 0; full_output_height = 0;
        bus_gnt = 0; ready = 0; data_bus = 0; m_ready = 1; rmode = 0; lat = 1; gdly = 0;
        spur = 0; gcnt = 0; mcnt = 0; mreal = 0; stall_left = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0000 | DW'(i);
        step(3);
        chk("reset_state", {done, busy, bus_req, mem_sel, mem_w, m_valid, m_last, address_bus, m_data}, 0);
        rst = 0;
        step(2);

        // directed table
        for (int t = 0; t < 7; t++) begin
            launch(tbl[t].w, tbl[t].h, tbl[t].base, tbl[t].l, tbl[t].gd, tbl[t].rm, 0);
            finish_drain();
            chk("tbl_n", got_q.size(), tbl[t].exp_n);
            if (got_q.size() > 0) begin
                chk("tbl_first", got_q[0], tbl[t].exp_first);
                chk("tbl_lastw", got_q[got_q.size() - 1], tbl[t].exp_last);
            end
            step(2);
        end

        // 3x3 region holding 1..9
        for (int i = 0; i < 9; i++) mem[16'h0200 + i] = DW'(i + 1);
        launch(3, 3, 16'h0200, 1, 0, 0, 0);
        finish_drain();
        for (int i = 0; i < 9 && i < got_q.size(); i++) chk("seq_1to9", got_q[i], i + 1);
        step(2);

        // sign handling on the push path
        rv = '{32'hFFFF_FFFB, 32'h3, 32'hFFFF_FFFF, 32'h0};
`ifdef NMCU_DRAIN_RELU_EN
        rexp = '{32'h0, 32'h3, 32'h0, 32'h0};
`else
        rexp = '{32'hFFFF_FFFB, 32'h3, 32'hFFFF_FFFF, 32'h0};
`endif
        for (int i = 0; i < 4; i++) mem[16'h0400 + i] = rv[i];
        launch(2, 2, 16'h0400, 1, 0, 0, 0);
        finish_drain();
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("relu_word", got_q[i], rexp[i]);
        step(2);

        // reset in the middle of a 14x14 drain, then a clean rerun
        launch(14, 14, 16'h0300, 1, 0, 0, 0);
        k = 0;
        while (got_q.size() < 4 && k < 400) begin step(1); k++; end
        chk("mid_words_seen", got_q.size() >= 4, 1);
        rst = 1;
        step(1);
        chk("rst_outputs", {done, busy, bus_req, mem_sel, mem_w, m_valid, m_last, address_bus, m_data}, 0);
        rst = 0;
        step(6);
        chk("rst_no_done", done_cnt, 0);
        launch(14, 14, 16'h0300, 1, 0, 0, 0);
        finish_drain();
        if (got_q.size() > 0) chk("rerun_first", got_q[0], 32'h1000_0300);
        step(2);

        // randomized drains
        for (int r = 0; r < 24; r++) begin
            int w, h;
            logic [AW-1:0] b;
            w = $urandom_range(0, 10); h = $urandom_range(0, 10);
            b = AW'($urandom);
            for (int i = 0; i < w * h; i++) mem[AW'(b + AW'(i))] = $urandom;
            launch(w, h, b, $urandom_range(0, 3), $urandom_range(0, 5),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            finish_drain();
            step($urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/nmcu_out_drain.md
# nmcu_out_drain

Read-back stage that sits directly downstream of `nmcu_ctrl`. Once the NMCU array reports done, it reads the convolution result region (`full_output_width × full_output_height` words at `output_addr`) from the shared memory. It streams the words out in row-major order on a valid/ready interface, with a last flag, through a small skid FIFO. It owns the memory bus only while it holds a grant.

## Interface
- `ADDR_WIDTH`, 16: memory address width
- `DATABUS_WIDTH`, 32: memory/stream word width
- `MAX_INPUT_DIM`, 16: sets the dimension field width, `DIM_W = $clog2(MAX_INPUT_DIM)+1`
- `FIFO_DEPTH`, 4: output buffer depth, power of two, ≥2

Ports:
- `clk` in 1: clock; single clock domain
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: begin drain; sampled only in IDLE
- `done` out 1: one-cycle pulse when the drain completes
- `busy` out 1: high in any state other than IDLE
- `output_addr` in ADDR_WIDTH: base address of the result region; latched at start
- `full_output_width` in DIM_W: columns; latched at start
- `full_output_height` in DIM_W: rows; latched at start
- `bus_req` out 1: request ownership of the memory bus
- `bus_gnt` in 1: ownership granted; must stay high until `bus_req` drops
- `mem_sel` out 1: memory select
- `mem_w` out 1: write enable; always 0
- `address_bus` out ADDR_WIDTH: read address
- `data_bus` in DATABUS_WIDTH: read data; valid while `ready` is high
- `ready` in 1: memory read complete
- `m_valid` out 1, `m_data` out DATABUS_WIDTH, `m_last` out 1: output stream
- `m_ready` in 1: stream consumer accepts the word

## Operation
- States: IDLE → REQ → READ → GAP → READ … → FLUSH → DONE → IDLE.
- IDLE: on `start`, latch the base address, `count = W*H` (2·DIM_W bits) and `rd_idx = 0`. If `count == 0`, go directly to DONE. Otherwise go to REQ.
- REQ: `bus_req = 1`. Wait for `bus_gnt`, then go to READ.
- READ: issue a read only if FIFO occupancy < FIFO_DEPTH; otherwise hold `mem_sel = 0` in READ.
  - While reading, `mem_sel = 1` and `address_bus = base + rd_idx`, held until `ready` is sampled high.
  - On that edge: push `data_bus` into the FIFO, then `rd_idx++`.
  - If `rd_idx == count` after the increment, go to FLUSH. Otherwise go to GAP.
- GAP: exactly one cycle with `mem_sel = 0`, then return to READ.
- FLUSH: drop `bus_req`. Wait until the FIFO is empty and the last word has been accepted.
- DONE: `done = 1` for one cycle, then go to IDLE.
- Addresses wrap modulo 2^ADDR_WIDTH.
- One outstanding read at most. `ready` seen while `mem_sel = 0` is ignored.
- Stream ordering: `m_last = 1` only with word index `count−1`.
- Stream rule: once `m_valid` rises, `m_data` and `m_last` stay stable until `m_valid & m_ready`.
- Simultaneous FIFO push and pop when full is not possible, because reads are gated by occupancy. Push and pop in the same cycle leave occupancy unchanged.
- `start` asserted while busy is ignored. Inputs changing mid-drain have no effect.
- `rst` mid-operation: return to IDLE, flush the FIFO, drop `bus_req` and `mem_sel`, and produce no `done`.

## Timing
- Reset values: `done`, `busy`, `bus_req`, `mem_sel`, `mem_w`, `m_valid`, `m_last` = 0; `address_bus` and `m_data` = 0.
- `busy` rises the cycle after `start`.
- `bus_req` rises the cycle after `start`. The first `mem_sel` comes the cycle after `bus_gnt` is sampled.
- FIFO is first-word-fall-through: `m_valid` rises the cycle after the push edge.
- Per word, with memory latency L: L+1 cycles of `mem_sel` high, plus one GAP cycle.
- With `m_ready` held high, the stream sustains one word per (L+2) cycles.
- `done` pulses the cycle after the final `m_valid & m_ready` handshake. For a zero-size drain, `done` pulses 2 cycles after `start`.

## Configuration
- `NMCU_DRAIN_RELU_EN` defined: each word is treated as signed two's complement on the push path, and negative values are replaced by 0 before the FIFO. No added latency.
- `NMCU_DRAIN_RELU_EN` undefined: words pass bit-exact.

## Structure
- Shared package `nmcu_pkg` holds:
  - the drain state enum (IDLE, REQ, READ, GAP, FLUSH, DONE);
  - the `DIM_W` derivation function;
  - the default width constants shared with `nmcu_ctrl`.
- One sub-module, `nmcu_drain_fifo`: synchronous first-word-fall-through FIFO with occupancy output, parameterised by depth and width.

## Test plan
- 3×3 region at 0x0200 holding 1..9, L=1, `m_ready = 1`, grant immediate:
  - stream is 1..9 in order, with `m_last` only on 9;
  - `done` pulses once; addresses issued are 0x0200..0x0208.
- Same region with `m_ready` low for 20 cycles after the first word:
  - at most FIFO_DEPTH reads are issued, then `mem_sel` stays low;
  - no word is lost or duplicated, and `m_data` is stable while stalled.
- `full_output_width = 0`, then `start`: no `bus_req`, no `mem_sel`, no stream words; `done` 2 cycles after `start`.
- `bus_gnt` delayed 7 cycles: `mem_sel` stays 0 until the cycle after the grant; output is otherwise identical to the 3×3 case.
- 2×2 region holding {−5, 3, −1, 0}:
  - with `NMCU_DRAIN_RELU_EN`: {0, 3, 0, 0};
  - without it: {−5, 3, −1, 0}.
- `rst` asserted after 4 words of a 14×14 drain:
  - next cycle: all outputs are at reset values and `done` never pulses;
  - a fresh `start` then drains all 196 words from index 0.
